// File: rtl/key_click_decoder_pkg.sv
// Shared constants for the click decoder: state encodings, window width and default window length.
package key_click_decoder_pkg;
  localparam int WIN_W = 24;
  localparam logic [WIN_W-1:0] CNT_WIN_DEF = 24'd14_999_999;  // 300 ms @ 50 MHz, minus one

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT2 = 2'd1,
    ST_WAIT3 = 2'd2
  } state_t;
endpackage

// File: rtl/key_click_decoder_click_win_timer.sv
// Click window counter: clears on a press, counts while a group is open, parks at CNT_WIN.
module click_win_timer
  import key_click_decoder_pkg::*;
#(
  parameter logic [WIN_W-1:0] CNT_WIN = CNT_WIN_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [WIN_W-1:0] win_cnt;

  assign expired = (win_cnt == CNT_WIN);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)            win_cnt <= '0;
    else if (clear)            win_cnt <= '0;
    else if (run && !expired)  win_cnt <= win_cnt + WIN_W'(1);
  end
endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced key presses into single/double(/triple) click pulses.
// Optional third-press detection is enabled by defining TRIPLE_CLICK_EN.
module key_click_decoder
  import key_click_decoder_pkg::*;
#(
  parameter logic [WIN_W-1:0] CNT_WIN = CNT_WIN_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  output logic single_click,
  output logic double_click,
  output logic triple_click,
  output logic busy
);
  state_t state, state_nxt;
  logic   single_nxt, double_nxt;
  logic   expired;

  // Every press restarts the window; a press always takes priority over expiry.
  click_win_timer #(.CNT_WIN(CNT_WIN)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (key_flag),
    .run       (state != ST_IDLE),
    .expired   (expired)
  );

`ifdef TRIPLE_CLICK_EN
  logic triple_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
`ifdef TRIPLE_CLICK_EN
    triple_nxt = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (key_flag) state_nxt = ST_WAIT2;
      ST_WAIT2: begin
        if (key_flag) begin
`ifdef TRIPLE_CLICK_EN
          state_nxt = ST_WAIT3;
`else
          double_nxt = 1'b1;
          state_nxt  = ST_IDLE;
`endif
        end else if (expired) begin
          single_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
`ifdef TRIPLE_CLICK_EN
      ST_WAIT3: begin
        if (key_flag) begin
          triple_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (expired) begin
          double_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
    end else begin
      state        <= state_nxt;
      single_click <= single_nxt;
      double_click <= double_nxt;
    end
  end

`ifdef TRIPLE_CLICK_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) triple_click <= 1'b0;
    else            triple_click <= triple_nxt;
  end
`else
  assign triple_click = 1'b0;
`endif

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench for key_click_decoder with a short window (CNT_WIN=9).
module tb_key_click_decoder;
  localparam logic [23:0] CW = 24'd9;
  localparam int WIN = 10;  // clocks from a press to expiry
`ifdef TRIPLE_CLICK_EN
  localparam int MAXP = 3;
`else
  localparam int MAXP = 2;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_flag = 1'b0;
  logic single_click, double_click, triple_click, busy;

  int checks = 0;
  int failures = 0;

  key_click_decoder #(.CNT_WIN(CW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_flag     (key_flag),
    .single_click (single_click),
    .double_click (double_click),
    .triple_click (triple_click),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a group is a list of press times; it closes on reaching
  // MAXP presses or WIN clocks after its latest press.
  int   ncyc = 0;
  int   presses[$];
  logic [3:0] exp_o = 4'b0;  // {single, double, triple, busy}

  task automatic model_edge(input logic f);
    logic [2:0] ev;
    ev = 3'b000;
    if (f) begin
      presses.push_back(ncyc);
      if (presses.size() == MAXP) begin
        ev[3 - MAXP] = 1'b1;
        presses.delete();
      end
    end else if (presses.size() > 0 && ncyc - presses[$] == WIN) begin
      ev[3 - presses.size()] = 1'b1;
      presses.delete();
    end
    exp_o = {ev, presses.size() > 0};
  endtask

  task automatic check(input string tag);
    logic [3:0] obs;
    obs = {single_click, double_click, triple_click, busy};
    checks++;
    assert (obs === exp_o) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b (single,double,triple,busy)",
             tag, ncyc, obs, exp_o);
    end
  endtask

  task automatic step(input logic f, input string tag);
    @(negedge sys_clk);
    key_flag = f;
    @(posedge sys_clk);
    ncyc++;
    model_edge(f);
    #1;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, tag);
  endtask

  task automatic hold_reset(input int n);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    presses.delete();
    exp_o = 4'b0;
    #1;
    check("reset_async");
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      ncyc++;
      #1;
      check("reset_hold");
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, then 50 idle clocks
    hold_reset(3);
    idle(50, "idle50");

    // Single press -> single_click after edge t+10
    step(1'b1, "single_press");
    idle(14, "single_wait");

    // Presses at t and t+5
    step(1'b1, "double_p1");
    idle(4, "double_gap");
    step(1'b1, "double_p2");
    idle(16, "double_wait");

    // Presses at t, t+4, t+8
    step(1'b1, "triple_p1");
    idle(3, "triple_gap1");
    step(1'b1, "triple_p2");
    idle(3, "triple_gap2");
    step(1'b1, "triple_p3");
    idle(14, "triple_wait");

    // Second press lands exactly on win_cnt==CNT_WIN
    step(1'b1, "edge_p1");
    idle(9, "edge_gap");
    step(1'b1, "edge_p2");
    idle(14, "edge_wait");

    // Press right after a pulse opens a new group
    step(1'b1, "b2b_p1");
    idle(9, "b2b_gap");
    step(1'b0, "b2b_expire");
    step(1'b1, "b2b_p2");
    idle(14, "b2b_wait");

    // Reset mid-window discards the group
    step(1'b1, "rst_p1");
    idle(3, "rst_gap");
    hold_reset(2);
    idle(15, "rst_after");
    step(1'b1, "rst_new_press");
    idle(14, "rst_new_wait");

    // Randomized press trains
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 5) == 0), "random");
    idle(15, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", ncyc);
    $fatal(1, "timeout");
  end
endmodule
